half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder.sv | 69 ++++++
 tb/tb_half_adder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// Registered multi-lane half adder: per-lane sum/carry with one-cycle latency.
// Optional lane-carry counter is enabled by defining HALF_ADDER_CARRY_CNT_EN.
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             out_valid
`ifdef HALF_ADDER_CARRY_CNT_EN
  ,
  output logic [15:0]      carry_cnt
`endif
);

  // Valid semantics: no backpressure. a/b are consumed on every rising edge
  // with in_valid=1; out_valid is high for exactly the cycle after each
  // consumed input, while s/c keep the last result until the next one.

  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] carry_next;

  assign sum_next   = a ^ b;
  assign carry_next = a & b;

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s <= sum_next;
        c <= carry_next;
      end
    end
  end

`ifdef HALF_ADDER_CARRY_CNT_EN
  // Seven bits covers the largest lane count (64).
  logic [6:0]  lane_cnt;
  logic [16:0] cnt_sum;

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_cnt = lane_cnt + 7'(carry_next[i]);
    end
    cnt_sum = {1'b0, carry_cnt} + 17'(lane_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (in_valid) begin
      carry_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

  // A lane can never produce sum and carry together.
  sum_carry_exclusive: assert property (@(posedge clk) (s & c) == '0);

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: WIDTH=1 and WIDTH=4 instances driven side by side and
// compared each cycle against an arithmetic per-lane reference model.
module tb_half_adder;

  logic       clk;
  logic       rst;
  logic       v1, a1, b1;
  logic       v4;
  logic [3:0] a4, b4;
  logic       s1, c1, ov1;
  logic [3:0] s4, c4;
  logic       ov4;
`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [15:0] cnt1, cnt4;
`endif

  half_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .s(s1), .c(c1), .out_valid(ov1)
`ifdef HALF_ADDER_CARRY_CNT_EN
    , .carry_cnt(cnt1)
`endif
  );

  half_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
    .s(s4), .c(c4), .out_valid(ov4)
`ifdef HALF_ADDER_CARRY_CNT_EN
    , .carry_cnt(cnt4)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  int    errors = 0;
  int    checks = 0;
  string phase  = "init";
  logic [11:0] exp_q[$];
  int    cnt_q[$];

  logic       m_ov1, m_s1, m_c1;
  logic       m_ov4;
  logic [3:0] m_s4, m_c4;
  int         m_cnt1 = 0;
  int         m_cnt4 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  // Reference: each lane adds two one-bit integers; sum bit is the low digit,
  // carry the high digit of that two-digit binary result.
  task automatic lane_model(input int w, input logic [3:0] a, input logic [3:0] b,
                            output logic [3:0] s, output logic [3:0] c, output int ncarry);
    s = '0;
    c = '0;
    ncarry = 0;
    for (int i = 0; i < w; i++) begin
      int t;
      t = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
      ncarry += t / 2;
    end
  endtask

  function automatic int sat_add(input int acc, input int inc);
    return (acc + inc > 65535) ? 65535 : acc + inc;
  endfunction

  // driver: apply at negedge, model at posedge, check 1 time unit later
  task automatic step(input logic r, input logic va, input logic aa, input logic bb,
                      input logic vb, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] ts, tc;
    int         n;
    logic [11:0] e;
    int          ecnt;
    @(negedge clk);
    rst = r;
    v1 = va; a1 = aa; b1 = bb;
    v4 = vb; a4 = a;  b4 = b;
    @(posedge clk);
    if (r) begin
      {m_ov1, m_s1, m_c1} = '0;
      m_ov4 = 1'b0; m_s4 = '0; m_c4 = '0;
      m_cnt1 = 0; m_cnt4 = 0;
    end else begin
      m_ov1 = va;
      if (va) begin
        lane_model(1, {3'b0, aa}, {3'b0, bb}, ts, tc, n);
        m_s1 = ts[0]; m_c1 = tc[0];
        m_cnt1 = sat_add(m_cnt1, n);
      end
      m_ov4 = vb;
      if (vb) begin
        lane_model(4, a, b, ts, tc, n);
        m_s4 = ts; m_c4 = tc;
        m_cnt4 = sat_add(m_cnt4, n);
      end
    end
    exp_q.push_back({m_ov1, m_s1, m_c1, m_ov4, m_s4, m_c4});
    cnt_q.push_back(m_cnt4);
    #1;
    e    = exp_q.pop_front();
    ecnt = cnt_q.pop_front();
    check("ov1", 64'(ov1), 64'(e[11]));
    check("s1",  64'(s1),  64'(e[10]));
    check("c1",  64'(c1),  64'(e[9]));
    check("ov4", 64'(ov4), 64'(e[8]));
    check("s4",  64'(s4),  64'(e[7:4]));
    check("c4",  64'(c4),  64'(e[3:0]));
`ifdef HALF_ADDER_CARRY_CNT_EN
    check("cnt4", 64'(cnt4), 64'(ecnt));
`else
    if (ecnt < 0) $display("negative carry model count");
`endif
  endtask

  logic [3:0] ra, rb;

  initial begin
    rst = 1'b1; v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; v4 = 1'b0; a4 = '0; b4 = '0;

    phase = "reset";
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);

    phase = "truth";
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check("tt00", 64'({s1, c1}), 64'(2'b00));
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    check("tt01", 64'({s1, c1}), 64'(2'b10));
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check("tt10", 64'({s1, c1}), 64'(2'b10));
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    check("tt11", 64'({s1, c1}), 64'(2'b01));

    phase = "lanes4";
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 4'b1010);
    check("s4_dir", 64'(s4), 64'(4'b0110));
    check("c4_dir", 64'(c4), 64'(4'b1000));

    phase = "hold";
    for (int i = 0; i < 6; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step(1'b0, 1'b0, ra[0], rb[0], 1'b0, ra, rb);
    end
    check("s4_held", 64'(s4), 64'(4'b0110));

    phase = "rst_valid";
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'h3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), ra[3], rb[3],
           ($urandom_range(0, 3) != 0), ra, rb);
    end

`ifdef HALF_ADDER_CARRY_CNT_EN
    phase = "cnt";
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF);
    check("cnt12", 64'(cnt4), 64'd12);
    phase = "cnt_sat";
    repeat (16400) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF);
    check("cnt_sat", 64'(cnt4), 64'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
